// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-period timer issuing per-bit shift strobes and a packet-done pulse
// Optional BIT_TIMER_MIDSAMPLE_EN moves the first strobe of each packet to mid-bit.
module bit_timer #(
    parameter int CNT_BITS   = 4,
    parameter int BIT_PERIOD = 10,
    parameter int NUM_BITS   = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_timer,
    output logic                shift_strobe,
    output logic                packet_done,
    output logic [CNT_BITS-1:0] bit_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] PERIOD_C = CNT_BITS'(BIT_PERIOD);
    localparam logic [CNT_BITS-1:0] NUM_C    = CNT_BITS'(NUM_BITS);
    localparam logic [CNT_BITS-1:0] ONE_C    = CNT_BITS'(1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] clk_cnt_q, clk_cnt_d;
    logic [CNT_BITS-1:0] bit_count_q, bit_count_d;
    logic [CNT_BITS-1:0] strobe_pt;
    logic [CNT_BITS-1:0] bit_count_inc;
    logic                at_strobe;

`ifdef BIT_TIMER_MIDSAMPLE_EN
    localparam logic [CNT_BITS-1:0] MID_C = CNT_BITS'(BIT_PERIOD / 2);
    // No strobe issued yet in this packet means we are still on the first bit.
    assign strobe_pt = (bit_count_q == '0) ? MID_C : PERIOD_C;
`else
    assign strobe_pt = PERIOD_C;
`endif

    assign at_strobe     = (state_q == COUNT) && (clk_cnt_q == strobe_pt);
    assign bit_count_inc = bit_count_q + ONE_C;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_count_d = bit_count_q;
        unique case (state_q)
            IDLE: begin
                if (enable_timer) begin
                    state_d     = COUNT;
                    clk_cnt_d   = ONE_C;
                    bit_count_d = '0;
                end
            end
            COUNT: begin
                // Dropping enable aborts the packet, even on a strobe edge.
                if (!enable_timer) begin
                    state_d     = IDLE;
                    clk_cnt_d   = '0;
                    bit_count_d = '0;
                end else if (at_strobe) begin
                    clk_cnt_d   = ONE_C;
                    bit_count_d = bit_count_inc;
                    if (bit_count_inc == NUM_C) begin
                        state_d = DONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + ONE_C;
                end
            end
            DONE: begin
                state_d     = IDLE;
                clk_cnt_d   = '0;
                bit_count_d = '0;
            end
            default: begin
                state_d     = IDLE;
                clk_cnt_d   = '0;
                bit_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign shift_strobe = at_strobe;
    assign packet_done  = (state_q == DONE);
    assign bit_count    = bit_count_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bit_timer.sv
// tb/tb_bit_timer.sv - scoreboard bench for bit_timer: strobe and done edges checked against queued expectations
module tb_bit_timer;

    localparam int CB = 4;
    localparam int BP = 10;
    localparam int NB = 9;
`ifdef BIT_TIMER_MIDSAMPLE_EN
    localparam int FIRST_SP = BP / 2;
`else
    localparam int FIRST_SP = BP;
`endif
    // Edge after which packet_done is visible, relative to E0.
    localparam int DONE_REL = FIRST_SP + (NB - 1) * BP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable_timer = 1'b0;
    logic          shift_strobe;
    logic          packet_done;
    logic [CB-1:0] bit_count;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int base, base2, base3, base4;

    int strobe_q[$];
    int strobe_bc_q[$];
    int done_q[$];

    bit_timer #(.CNT_BITS(CB), .BIT_PERIOD(BP), .NUM_BITS(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .bit_count    (bit_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    endtask

    // Queue every strobe of a packet starting at E0=b whose edge lies before b+limit.
    task automatic push_packet(input int b, input int limit);
        int rel;
        for (int i = 0; i < NB; i++) begin
            rel = FIRST_SP - 1 + i * BP;
            if (rel < limit) begin
                strobe_q.push_back(b + rel);
                strobe_bc_q.push_back(i);
            end
        end
        if (DONE_REL < limit) done_q.push_back(b + DONE_REL);
    endtask

    task automatic step();
        int e;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        chk("exclusive", int'(shift_strobe && packet_done), 0);
        if (shift_strobe) begin
            if (strobe_q.size() > 0) begin
                e = strobe_q.pop_front();
                chk("strobe_edge", edge_n, e);
                chk("strobe_bc", int'(bit_count), strobe_bc_q.pop_front());
                chk("strobe_busy", int'(busy), 1);
            end else begin
                chk("strobe_unexpected", edge_n, -1);
            end
        end
        if (packet_done) begin
            if (done_q.size() > 0) begin
                e = done_q.pop_front();
                chk("done_edge", edge_n, e);
                chk("done_bc", int'(bit_count), NB);
                chk("done_busy", int'(busy), 1);
            end else begin
                chk("done_unexpected", edge_n, -1);
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_strobe"}, int'(shift_strobe), 0);
        chk({tag, "_done"}, int'(packet_done), 0);
        chk({tag, "_bc"}, int'(bit_count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        enable_timer = 1'b1;
        step();
        chk_idle("reset1");
        step();
        chk_idle("reset2");

        // Full packet, enable held high throughout.
        rst = 1'b0;
        step();
        base = edge_n;
        push_packet(base, 1000);
        chk("first_busy", int'(busy), 1);
        chk("first_bc", int'(bit_count), 0);
        while (edge_n < base + DONE_REL + 1) step();
        chk("after_done_busy", int'(busy), 0);
        chk("after_done_bc", int'(bit_count), 0);

        // Restart with enable still high, then abort at E25.
        base2 = base + DONE_REL + 2;
        push_packet(base2, 25);
        while (edge_n < base2 + 24) step();
        chk("restart_busy", int'(busy), 1);
        enable_timer = 1'b0;
        step();
        chk("abort_bc", int'(bit_count), 0);
        chk("abort_busy", int'(busy), 0);
        for (int i = 0; i < 60; i++) step();
        chk("abort_strobe_left", strobe_q.size(), 0);
        chk("abort_done_left", done_q.size(), 0);

        // Reset mid-packet at E39, restart at E41.
        enable_timer = 1'b1;
        step();
        base3 = edge_n;
        push_packet(base3, 39);
        while (edge_n < base3 + 38) step();
        rst = 1'b1;
        step();
        chk("midrst_bc", int'(bit_count), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_strobe", int'(shift_strobe), 0);
        rst = 1'b0;
        enable_timer = 1'b0;
        step();
        chk("midrst_idle_busy", int'(busy), 0);
        enable_timer = 1'b1;
        step();
        base4 = edge_n;
        push_packet(base4, 1000);
        while (edge_n < base4 + DONE_REL + 1) step();
        enable_timer = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("final_busy", int'(busy), 0);
        chk("final_strobe_left", strobe_q.size(), 0);
        chk("final_done_left", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
